// File: rtl/approx_add_rr_arbiter.sv
// -----------------------------------------------------------------------------
// approx_add_rr_arbiter
//
// Purpose:
//   Shares one registered approximate/exact adder among NREQ requesters.
//   A round-robin arbiter grants at most one request per cycle. The granted
//   operands are added in the same cycle and captured, with the requester ID,
//   in a single-entry result register that honours consumer backpressure.
//   The approximate adder has an exact upper part of W-APPROX_L bits and an
//   OR-based low part of APPROX_L bits with no carry into the upper part.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   req_valid  in   NREQ     request pending, one bit per requester
//   req_ready  out  NREQ     one-hot grant (zero when no issue is possible)
//   req_a      in   NREQ*W   packed operand A, requester i at [i*W +: W]
//   req_b      in   NREQ*W   packed operand B, same packing
//   req_exact  in   NREQ     1 = exact add, 0 = approximate add
//   rsp_valid  out  1        result register holds a valid result
//   rsp_ready  in   1        consumer accepts the result
//   rsp_id     out  IDW      requester that owns the result
//   rsp_sum    out  W+1      result including carry-out
// -----------------------------------------------------------------------------
module approx_add_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int W        = 16,
  parameter int APPROX_L = 12,
  parameter int IDW      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_exact,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W:0]        rsp_sum
);

  localparam int L = APPROX_L;

  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [W:0]       r_rsp_sum;
  logic [IDW-1:0]   r_ptr;

  logic             w_can_issue;
  logic             w_found;
  logic             w_xfer;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gid;
  logic [IDW-1:0]   w_idx;
  logic [IDW-1:0]   w_ptr_next;

  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic             w_exact;
  logic [W:0]       w_sum_exact;
  logic [W:0]       w_sum_approx;
  logic [W:0]       w_sum;
  logic             w_and_seen;

  // A new result may be captured when the register is empty or being drained.
  assign w_can_issue = !r_rsp_valid || rsp_ready;

  // Round-robin search starting at r_ptr, wrapping at NREQ-1. Depends only on
  // req_valid, r_ptr and w_can_issue, never on operand data.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise synthesis infers a latch to hold the old value.
    w_grant = '0;
    w_gid   = '0;
    w_found = 1'b0;
    w_idx   = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gid   = w_idx;
      end
      w_idx = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    end
    if (w_found && w_can_issue && !rst) begin
      w_grant[w_gid] = 1'b1;
    end
  end

  assign req_ready  = w_grant;
  assign w_xfer     = |w_grant;
  assign w_ptr_next = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;

  // Operand mux for the granted requester.
  assign w_a     = req_a[w_gid*W +: W];
  assign w_b     = req_b[w_gid*W +: W];
  assign w_exact = req_exact[w_gid];

  // Approximate low part: bit i is a|b, forced to 1 if any higher low-part
  // position generates (a&b). Scanning from the top keeps a running flag of
  // "a generate exists strictly above this bit".
  always_comb begin
    w_sum_exact  = {1'b0, w_a} + {1'b0, w_b};
    w_sum_approx = '0;
    w_and_seen   = 1'b0;
    w_sum_approx[W:L] = {1'b0, w_a[W-1:L]} + {1'b0, w_b[W-1:L]};
    for (int i = L - 1; i >= 0; i--) begin
      w_sum_approx[i] = w_a[i] | w_b[i] | w_and_seen;
      w_and_seen      = w_and_seen | (w_a[i] & w_b[i]);
    end
    w_sum = w_exact ? w_sum_exact : w_sum_approx;
  end

  // A capture has priority over a pop: same-cycle pop and accept simply
  // overwrites the register, giving one result per cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from pre-edge values, independent of statement order.
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gid;
      r_rsp_sum   <= w_sum;
      r_ptr       <= w_ptr_next;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;

endmodule

// File: tb/tb_approx_add_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_approx_add_rr_arbiter
//
// Purpose:
//   Self-checking bench for approx_add_rr_arbiter. A driver applies directed
//   and random stimulus, predicts each grant from a round-robin model and
//   pushes the expected {id, sum} into a scoreboard queue. A monitor on the
//   falling edge compares the response register against the queue head.
// -----------------------------------------------------------------------------
module tb_approx_add_rr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int L    = 12;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_exact;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W:0]        rsp_sum;

  approx_add_rr_arbiter #(
    .NREQ(NREQ), .W(W), .APPROX_L(L), .IDW(IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_exact (req_exact),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         id;
    logic [W:0] sum;
  } rsp_t;

  rsp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  // Requester-side state: operands held until granted.
  logic [W-1:0] op_a [NREQ];
  logic [W-1:0] op_b [NREQ];
  logic         op_ex[NREQ];
  int           m_ptr;
  int           last_g;

  // Directed response checks applied at the start of the next cycle.
  bit           chk_id_en;
  bit           chk_sum_en;
  int           exp_id;
  logic [W:0]   exp_sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the functional rules: exact sum, or exact upper
  // sum plus a low part where everything below the highest generate is 1.
  function automatic logic [W:0] ref_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ex);
    int up, low, ab, h;
    if (ex) return (W+1)'(int'(a) + int'(b));
    up  = (int'(a) >> L) + (int'(b) >> L);
    low = (int'(a) | int'(b)) & ((1 << L) - 1);
    ab  = int'(a & b) & ((1 << L) - 1);
    if (ab != 0) begin
      h = 0;
      for (int j = 0; j < L; j++) if (ab[j]) h = j;
      low = low | ((1 << h) - 1);
    end
    return (W+1)'((up << L) | low);
  endfunction

  // Monitor: the queue holds exactly the entry expected in the result register.
  always @(negedge clk) begin
    if (!rst) begin
      check("rsp_valid", 32'(rsp_valid), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        check("rsp_id", 32'(rsp_id), 32'(sb_q[0].id));
        check("rsp_sum", 32'(rsp_sum), 32'(sb_q[0].sum));
        if (rsp_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic drive_ops(input logic [NREQ-1:0] v, input logic rr);
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
      req_exact[i]    = op_ex[i];
    end
  endtask

  // One clock cycle: drive after the rising edge, predict after the monitor.
  task automatic cycle(input logic [NREQ-1:0] v, input logic rr);
    logic [NREQ-1:0] exp_rdy;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_ops(v, rr);
    if (chk_id_en)  check("dir_id", 32'(rsp_id), 32'(exp_id));
    if (chk_sum_en) check("dir_sum", 32'(rsp_sum), 32'(exp_sum));
    chk_id_en  = 1'b0;
    chk_sum_en = 1'b0;
    @(negedge clk);
    #1;
    exp_rdy = '0;
    last_g  = -1;
    if (sb_q.size() == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (last_g < 0 && v[idx]) last_g = idx;
      end
    end
    if (last_g >= 0) begin
      exp_rdy[last_g] = 1'b1;
      sb_q.push_back('{id: last_g, sum: ref_f(op_a[last_g], op_b[last_g], op_ex[last_g])});
      m_ptr = (last_g + 1) % NREQ;
    end
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
  endtask

  task automatic do_reset(input logic [NREQ-1:0] v);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_ops(v, 1'b1);
    @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    sb_q.delete();
    m_ptr = 0;
    @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_sum", 32'(rsp_sum), 32'h0);
    check("rst_req_ready2", 32'(req_ready), 32'h0);
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 16'hFFFF;
      1:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [NREQ-1:0] v;
    logic            rr;
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_exact = '0; rsp_ready = 1'b0;
    chk_id_en = 1'b0; chk_sum_en = 1'b0; exp_id = 0; exp_sum = '0;
    m_ptr = 0; last_g = -1;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = rand_op(); op_b[i] = rand_op(); op_ex[i] = 1'($urandom);
    end

    // 1: all requesters valid, full throughput, grants rotate 0,1,2,3,0.
    do_reset('0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin chk_id_en = 1'b1; exp_id = k - 1; end
      cycle(4'b1111, 1'b1);
    end

    // 2: requester 2 alone, exact 3+1.
    op_a[2] = 16'h0003; op_b[2] = 16'h0001; op_ex[2] = 1'b1;
    chk_id_en = 1'b1; exp_id = 0;
    cycle(4'b0100, 1'b1);
    chk_id_en = 1'b1; chk_sum_en = 1'b1; exp_id = 2; exp_sum = 17'h00004;

    // 3: approximate, generate at bit 11 forces lower bits to 1.
    op_a[0] = 16'h1803; op_b[0] = 16'h2801; op_ex[0] = 1'b0;
    cycle(4'b0001, 1'b1);
    chk_id_en = 1'b1; chk_sum_en = 1'b1; exp_id = 0; exp_sum = 17'h03FFF;

    // 4: approximate carry-out, then exact all-ones.
    op_a[1] = 16'hF000; op_b[1] = 16'h1000; op_ex[1] = 1'b0;
    cycle(4'b0010, 1'b1);
    chk_id_en = 1'b1; chk_sum_en = 1'b1; exp_id = 1; exp_sum = 17'h10000;
    op_a[3] = 16'hFFFF; op_b[3] = 16'hFFFF; op_ex[3] = 1'b1;
    cycle(4'b1000, 1'b1);
    chk_id_en = 1'b1; chk_sum_en = 1'b1; exp_id = 3; exp_sum = 17'h1FFFE;
    cycle(4'b0000, 1'b1);

    // 5: backpressure for 3 cycles, then same-cycle pop and accept.
    for (int k = 0; k < 3; k++) cycle(4'b0011, 1'b0);
    cycle(4'b0011, 1'b1);
    cycle(4'b0000, 1'b1);

    // 6: reset while a result is held and all requesters are valid.
    cycle(4'b1111, 1'b0);
    do_reset(4'b1111);
    cycle(4'b1111, 1'b1);
    check("post_rst_grant", 32'(last_g), 32'd0);
    cycle(4'b0000, 1'b1);

    // Random traffic with backpressure; operands held until granted.
    for (int n = 0; n < 400; n++) begin
      v  = NREQ'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      cycle(v, rr);
      for (int i = 0; i < NREQ; i++) begin
        if (i == last_g || !v[i]) begin
          op_a[i] = rand_op(); op_b[i] = rand_op(); op_ex[i] = 1'($urandom);
        end
      end
    end
    for (int k = 0; k < 3; k++) cycle(4'b0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
